ntt_cmd_sequencer: RTL and testbench

Synthesizable command sequencer that drives the NTT top-level `start`/`set_state` control pair from a programmable command table. It replaces hand-written start/set_state stimulus: each entry selects a mode, pulses start, then waits either for the core's done flag or for a fixed cycle count. It sits between the host/config bus and the NTT `top` control inputs, and is generalised in state width, table depth, start-pulse length and wait mode.

---
 rtl/ntt_cmd_sequencer.sv | 167 ++++++++++++++++
 tb/tb_ntt_cmd_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_cmd_sequencer.sv
// ntt_cmd_sequencer: walks a programmable command table and drives the NTT
// core start/set_state pair. Each entry pulses start for START_LEN cycles,
// then waits a fixed number of cycles or for core_done (with timeout).
// Optional build macro SEQ_LOOP_EN: after an error-free last entry the run
// restarts at entry 0 (seq_done pulses once per pass) until abort or timeout.
module ntt_cmd_sequencer #(
  parameter int STATE_W   = 3,
  parameter int NUM_CMD   = 8,
  parameter int CNT_W     = 16,
  parameter int START_LEN = 3,
  localparam int IDX_W    = $clog2(NUM_CMD)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_addr,
  input  logic [STATE_W-1:0] cfg_state,
  input  logic [CNT_W-1:0]   cfg_wait,
  input  logic               cfg_use_done,
  input  logic [IDX_W:0]     cfg_num,
  input  logic               go,
  input  logic               abort,
  input  logic               core_done,
  output logic [STATE_W-1:0] set_state,
  output logic               start,
  output logic               busy,
  output logic               seq_done,
  output logic               err,
  output logic [IDX_W-1:0]   cur_idx
);

  localparam int SL_W = (START_LEN > 1) ? $clog2(START_LEN) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_NEXT, S_FIN} state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [STATE_W-1:0]   r_tbl_state [NUM_CMD];
  logic [CNT_W-1:0]     r_tbl_wait  [NUM_CMD];
  logic [NUM_CMD-1:0]   r_tbl_use;

  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W:0]       r_num;
  logic [SL_W-1:0]      r_scnt;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_err;
  logic                 r_seq_done;

  logic [IDX_W:0]       w_n;
  logic [STATE_W-1:0]   w_ent_state;
  logic [CNT_W-1:0]     w_ent_wait;
  logic                 w_ent_use;
  logic                 w_last;
  logic                 w_start_end;
  logic                 w_expire;
  logic                 w_busy;
  logic                 w_timeout;

  // Requested entry count clipped to the table depth.
  assign w_n         = (cfg_num > (IDX_W+1)'(NUM_CMD)) ? (IDX_W+1)'(NUM_CMD) : cfg_num;
  assign w_ent_state = r_tbl_state[r_idx];
  assign w_ent_wait  = r_tbl_wait[r_idx];
  assign w_ent_use   = r_tbl_use[r_idx];
  assign w_last      = ({1'b0, r_idx} == (r_num - 1'b1));
  assign w_start_end = (r_scnt == SL_W'(START_LEN - 1));
  // Counter holds the remaining wait; the cycle it shows 1 (or 0) is the last one.
  assign w_expire    = (r_cnt <= CNT_W'(1));
  assign w_busy      = (r_state == S_START) || (r_state == S_WAIT) || (r_state == S_NEXT);
  // core_done in the expiring cycle wins over the timeout.
  assign w_timeout   = (r_state == S_WAIT) && w_ent_use && !core_done && w_expire;

  assign start    = (r_state == S_START);
  assign busy     = w_busy;
  assign set_state = w_busy ? w_ent_state : '0;
  assign seq_done = r_seq_done;
  assign err      = r_err;
  assign cur_idx  = r_idx;

  // Command table; writes are locked out while a sequence is running.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_CMD; i++) begin
        r_tbl_state[i] <= '0;
        r_tbl_wait[i]  <= '0;
      end
      r_tbl_use <= '0;
    end else if (cfg_we && !w_busy) begin
      r_tbl_state[cfg_addr] <= cfg_state;
      r_tbl_wait[cfg_addr]  <= cfg_wait;
      r_tbl_use[cfg_addr]   <= cfg_use_done;
    end
  end

  // Next-state selection; abort overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (go && (w_n != '0)) w_state_nxt = S_START;
      S_START: if (w_start_end) w_state_nxt = (w_ent_use || (w_ent_wait != '0)) ? S_WAIT : S_NEXT;
      S_WAIT: begin
        if (w_ent_use) begin
          if (core_done)     w_state_nxt = S_NEXT;
          else if (w_expire) w_state_nxt = S_FIN;
        end else if (w_expire) begin
          w_state_nxt = S_NEXT;
        end
      end
`ifdef SEQ_LOOP_EN
      S_NEXT:  w_state_nxt = S_START;
`else
      S_NEXT:  w_state_nxt = w_last ? S_FIN : S_START;
`endif
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (abort) w_state_nxt = S_IDLE;
  end

  // State register plus the per-state counters, index, error and done flags.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_num      <= '0;
      r_scnt     <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_seq_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_seq_done <= 1'b0;
      if (!abort) begin
        case (r_state)
          S_IDLE: if (go) begin
            r_num  <= w_n;
            r_err  <= 1'b0;
            r_idx  <= '0;
            r_scnt <= '0;
            if (w_n == '0) r_seq_done <= 1'b1;
          end
          S_START: begin
            r_scnt <= w_start_end ? '0 : r_scnt + 1'b1;
            if (w_start_end) r_cnt <= w_ent_wait;
          end
          S_WAIT: begin
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            if (w_timeout) r_err <= 1'b1;
          end
          S_NEXT: begin
            r_scnt <= '0;
            if (w_last) begin
              r_seq_done <= 1'b1;
`ifdef SEQ_LOOP_EN
              r_idx <= '0;
`endif
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ntt_cmd_sequencer.sv
// Testbench for ntt_cmd_sequencer: builds the expected per-cycle output trace
// of each sequence from the table contents and the planned core_done replies,
// then compares the DUT against it every cycle. Define SEQ_LOOP_EN to match
// a looping DUT build.
`timescale 1ns/1ps
module tb_ntt_cmd_sequencer;

  localparam int STATE_W   = 3;
  localparam int NUM_CMD   = 8;
  localparam int CNT_W     = 16;
  localparam int START_LEN = 3;
  localparam int IDX_W     = 3;
`ifdef SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               cfg_we = 1'b0;
  logic [IDX_W-1:0]   cfg_addr = '0;
  logic [STATE_W-1:0] cfg_state = '0;
  logic [CNT_W-1:0]   cfg_wait = '0;
  logic               cfg_use_done = 1'b0;
  logic [IDX_W:0]     cfg_num = '0;
  logic               go = 1'b0;
  logic               abort = 1'b0;
  logic               core_done = 1'b0;
  logic [STATE_W-1:0] set_state;
  logic               start;
  logic               busy;
  logic               seq_done;
  logic               err;
  logic [IDX_W-1:0]   cur_idx;

  ntt_cmd_sequencer #(
    .STATE_W(STATE_W), .NUM_CMD(NUM_CMD), .CNT_W(CNT_W), .START_LEN(START_LEN)
  ) dut (
    .clk(clk), .rstn(rstn), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_state(cfg_state), .cfg_wait(cfg_wait), .cfg_use_done(cfg_use_done),
    .cfg_num(cfg_num), .go(go), .abort(abort), .core_done(core_done),
    .set_state(set_state), .start(start), .busy(busy), .seq_done(seq_done),
    .err(err), .cur_idx(cur_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One expected cycle: outputs plus the stimulus to apply in that cycle.
  typedef struct {
    bit st; int ss; bit bz; bit sd; bit er; int ix;
    bit cd; bit ab; bit jk;
  } el_t;

  el_t q[$];
  int  m_state [NUM_CMD];
  int  m_wait  [NUM_CMD];
  bit  m_use   [NUM_CMD];
  int  resp    [NUM_CMD];
  bit  m_err;
  int  m_idx;
  bit  force_jk;

  int  n_checks, n_err;
  int  cyc, go_cyc, last_sd_cyc, n_sd, n_start;
  int  q_ss[$];
  bit  prev_start;

  bit  d_go, d_we, d_use;
  int  d_num, d_addr, d_st, d_wt;

  function automatic el_t mk(bit st, int ss, bit bz, bit sd, bit er, int ix);
    el_t e;
    e.st = st; e.ss = ss; e.bz = bz; e.sd = sd; e.er = er; e.ix = ix;
    e.cd = 1'($urandom_range(0, 1));
    e.ab = 1'b0;
    e.jk = bz && (force_jk || ($urandom_range(0, 3) == 0));
    return e;
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Expected trace of one run started by go: START_LEN start cycles per entry,
  // then the wait phase, then one bookkeeping cycle, and a final one-cycle
  // wrap-up with seq_done (or err on timeout).
  task automatic build(input int ncfg, input int passes, input int abort_at);
    int n, lim, ab;
    bit fail;
    el_t e;
    n = (ncfg > NUM_CMD) ? NUM_CMD : ncfg;
    ab = abort_at;
    fail = 1'b0;
    q.delete();
    if (n == 0) begin
      e = mk(0, 0, 0, 1, 0, 0);
      q.push_back(e);
    end else begin
      for (int p = 0; p < passes && !fail; p++) begin
        for (int i = 0; i < n && !fail; i++) begin
          for (int k = 0; k < START_LEN; k++) begin
            e = mk(1, m_state[i], 1, (p > 0 && i == 0 && k == 0), 0, i);
            q.push_back(e);
          end
          if (m_use[i]) begin
            lim = (m_wait[i] == 0) ? 1 : m_wait[i];
            if (resp[i] >= 0 && resp[i] < lim) begin
              for (int j = 0; j <= resp[i]; j++) begin
                e = mk(0, m_state[i], 1, 0, 0, i);
                e.cd = (j == resp[i]);
                q.push_back(e);
              end
            end else begin
              for (int j = 0; j < lim; j++) begin
                e = mk(0, m_state[i], 1, 0, 0, i);
                e.cd = 1'b0;
                q.push_back(e);
              end
              fail = 1'b1;
              e = mk(0, 0, 0, 0, 1, i);
              q.push_back(e);
            end
          end else begin
            for (int j = 0; j < m_wait[i]; j++) begin
              e = mk(0, m_state[i], 1, 0, 0, i);
              q.push_back(e);
            end
          end
          if (!fail) begin
            e = mk(0, m_state[i], 1, 0, 0, i);
            q.push_back(e);
          end
        end
      end
      if (!fail && !LOOP) begin
        e = mk(0, 0, 0, 1, 0, n - 1);
        q.push_back(e);
      end
      if (LOOP && !fail && (ab < 0 || ab >= q.size())) ab = q.size() - 1;
    end
    if (ab >= 0 && ab < q.size()) begin
      while (q.size() > ab + 1) void'(q.pop_back());
      e = q.pop_back();
      e.ab = 1'b1;
      q.push_back(e);
    end
  endtask

  // One clock cycle: compare outputs against the trace, then drive inputs.
  task automatic step();
    el_t e;
    @(negedge clk);
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      m_err = e.er;
      m_idx = e.ix;
    end else begin
      e = mk(0, 0, 0, 0, m_err, m_idx);
    end
    n_checks++;
    if (start !== e.st || set_state !== STATE_W'(e.ss) || busy !== e.bz ||
        seq_done !== e.sd || err !== e.er || cur_idx !== IDX_W'(e.ix)) begin
      n_err++;
      $display("FAIL cycle %0d outputs: got start=%0b set_state=%0d busy=%0b seq_done=%0b err=%0b cur_idx=%0d, expected start=%0b set_state=%0d busy=%0b seq_done=%0b err=%0b cur_idx=%0d",
               cyc, start, set_state, busy, seq_done, err, cur_idx,
               e.st, e.ss, e.bz, e.sd, e.er, e.ix);
    end
    if (start && !prev_start) q_ss.push_back(int'(set_state));
    prev_start = start;
    if (start) n_start++;
    if (seq_done) begin
      n_sd++;
      last_sd_cyc = cyc;
    end
    core_done = e.cd;
    abort     = e.ab;
    go        = d_go | e.jk;
    cfg_we    = d_we | e.jk;
    if (e.jk) begin
      cfg_addr     = IDX_W'($urandom_range(0, NUM_CMD - 1));
      cfg_state    = STATE_W'($urandom);
      cfg_wait     = CNT_W'($urandom_range(0, 12));
      cfg_use_done = 1'($urandom_range(0, 1));
      cfg_num      = (IDX_W+1)'($urandom_range(0, 15));
    end
    if (d_we) begin
      cfg_addr     = IDX_W'(d_addr);
      cfg_state    = STATE_W'(d_st);
      cfg_wait     = CNT_W'(d_wt);
      cfg_use_done = d_use;
    end
    if (d_go) begin
      cfg_num = (IDX_W+1)'(d_num);
      go_cyc  = cyc;
    end
    d_go = 1'b0;
    d_we = 1'b0;
  endtask

  task automatic write_entry(input int a, input int s, input int w, input bit u);
    d_we = 1'b1; d_addr = a; d_st = s; d_wt = w; d_use = u;
    step();
    m_state[a] = s; m_wait[a] = w; m_use[a] = u;
  endtask

  task automatic run_seq(input int ncfg, input int passes, input int abort_at);
    n_sd = 0; n_start = 0; q_ss.delete(); prev_start = 1'b0;
    d_go = 1'b1; d_num = ncfg;
    step();
    build(ncfg, passes, abort_at);
    while (q.size() > 0) step();
    step();
    step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; go = 1'b0; cfg_we = 1'b0; abort = 1'b0; core_done = 1'b0;
    repeat (5) @(negedge clk);
    rstn = 1'b1;
    q.delete();
    m_err = 1'b0; m_idx = 0;
    for (int i = 0; i < NUM_CMD; i++) begin
      m_state[i] = 0; m_wait[i] = 0; m_use[i] = 1'b0; resp[i] = -1;
    end
  endtask

  initial begin
    n_checks = 0; n_err = 0; cyc = 0; force_jk = 1'b0;
    d_go = 1'b0; d_we = 1'b0;

    // Reset, then idle outputs and a zero-length run.
    do_reset();
    repeat (3) step();
    chk("reset_outputs", {start, busy, seq_done, err, set_state, cur_idx}, 0);
    run_seq(0, 1, -1);
    chk("zero_n_seq_done_pulses", n_sd, 1);
    chk("zero_n_start_cycles", n_start, 0);

`ifndef SEQ_LOOP_EN
    // Fixed wait of 700 cycles on a single entry.
    write_entry(0, 1, 700, 1'b0);
    run_seq(1, 1, -1);
    chk("fixed_go_to_seq_done", last_sd_cyc - go_cyc, 705);
    chk("fixed_start_cycles", n_start, 3);
    chk("fixed_seq_done_pulses", n_sd, 1);

    // Done-mode chain of three entries, core_done 20 cycles into each wait.
    write_entry(0, 1, 100, 1'b1);
    write_entry(1, 2, 100, 1'b1);
    write_entry(2, 3, 100, 1'b1);
    for (int i = 0; i < NUM_CMD; i++) resp[i] = 20;
    run_seq(3, 1, -1);
    chk("chain_start_bursts", q_ss.size(), 3);
    if (q_ss.size() == 3) begin
      chk("chain_state_0", q_ss[0], 1);
      chk("chain_state_1", q_ss[1], 2);
      chk("chain_state_2", q_ss[2], 3);
    end
    chk("chain_seq_done_pulses", n_sd, 1);
    chk("chain_err", err, 0);
`endif

    // Timeout: core_done never arrives.
    write_entry(0, 1, 10, 1'b1);
    write_entry(1, 2, 10, 1'b1);
    for (int i = 0; i < NUM_CMD; i++) resp[i] = -1;
    run_seq(2, 1, -1);
    chk("timeout_err", err, 1);
    chk("timeout_start_cycles", n_start, START_LEN);
    chk("timeout_seq_done_pulses", n_sd, 0);
    run_seq(0, 1, -1);
    chk("go_clears_err", err, 0);

    // Abort in the second start cycle, with writes and go attempted while busy.
    write_entry(0, 1, 30, 1'b1);
    write_entry(1, 2, 4, 1'b0);
    write_entry(2, 3, 30, 1'b1);
    for (int i = 0; i < NUM_CMD; i++) resp[i] = 5;
    force_jk = 1'b1;
    run_seq(3, 1, 1);
    chk("abort_start_cycles", n_start, 2);
    chk("abort_seq_done_pulses", n_sd, 0);
    chk("abort_busy_after", busy, 0);
    run_seq(3, 1, -1);
    force_jk = 1'b0;

`ifdef SEQ_LOOP_EN
    // Looping: two fixed entries, three completed passes, then abort.
    write_entry(0, 1, 5, 1'b0);
    write_entry(1, 2, 5, 1'b0);
    run_seq(2, 4, 3 * 2 * (START_LEN + 5 + 1) + 1);
    chk("loop_seq_done_pulses", n_sd, 3);
    chk("loop_busy_after_abort", busy, 0);
`endif

    // Randomized table contents, replies, run lengths and aborts.
    for (int it = 0; it < 40; it++) begin
      for (int w = 0; w < int'($urandom_range(0, 3)); w++)
        write_entry(int'($urandom_range(0, NUM_CMD - 1)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
      for (int i = 0; i < NUM_CMD; i++) resp[i] = int'($urandom_range(0, 15)) - 1;
      run_seq(int'($urandom_range(0, 15)), LOOP ? 2 : 1,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 60)) : -1);
    end

    // Reset must clear the whole table.
    for (int i = 0; i < NUM_CMD; i++) write_entry(i, 7, 3, 1'b0);
    do_reset();
    step();
    run_seq(8, 1, -1);
    chk("post_reset_start_cycles", n_start, 8 * START_LEN);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
